// File: rtl/uart_tx_axi_slave.sv
// ---------------------------------------------------------------------------------------------
// uart_tx_axi_slave
//
// AXI4-Lite write sink for the CPU-side UART buffer. Every accepted 32-bit write is queued in a
// word FIFO, and each word is then sent on txd as four 8N1 bytes, least significant byte first.
// A read-only status word reports FIFO level and line activity.
//
// Parameters
//   DEPTH        FIFO depth in 32-bit words (power of two, >= 2)
//   CLK_PER_BIT  clk cycles per UART bit (>= 2)
//
// Ports
//   clk, rstn                 system clock, asynchronous active-low reset
//   s_aw*, s_w*, s_b*         AXI4-Lite write channels (address and strobes ignored)
//   s_ar*, s_r*               AXI4-Lite read channels (status at araddr[3:2] == 0, else 0)
//   txd                       UART serial output, idle high
//
// Status word: [0] empty, [1] full, [2] tx busy, [15:8] FIFO word count, rest 0.
// ---------------------------------------------------------------------------------------------
module uart_tx_axi_slave #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CLK_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rstn,
  // Write address / data / response
  input  logic [12:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  // Read address / data
  input  logic [12:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  // Serial line
  output logic        txd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

  // -------------------------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------------------------
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          r_awready;
  logic          r_bvalid;
  logic          r_arready;
  logic          r_rvalid;
  logic [31:0]   r_rdata;

  state_t        r_state;
  logic [31:0]   r_shift;
  logic [1:0]    r_byte_idx;
  logic [2:0]    r_bit_idx;
  logic [BW-1:0] r_baud;
  logic          r_txd;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_busy;
  logic          w_baud_last;
  logic [7:0]    w_count8;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata_next;
  logic          w_unused_ok;

  // -------------------------------------------------------------------------------------------
  // FIFO status and transfer strobes
  // -------------------------------------------------------------------------------------------
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // The ready pulse is only raised while both valids are present, so the handshake cycle is the
  // cycle in which r_awready is high and the master still holds both valids.
  assign w_push  = r_awready & s_awvalid & s_wvalid;

  // The FSM takes a word only from IDLE, so a pop is simply "idle and something queued".
  assign w_pop   = (r_state == StIdle) & ~w_empty;

  assign w_busy      = (r_state != StIdle);
  assign w_baud_last = (r_baud == BAUD_LAST);

  // -------------------------------------------------------------------------------------------
  // Word FIFO
  // -------------------------------------------------------------------------------------------
  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= s_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      // A simultaneous push and pop leaves the level unchanged.
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------------------------
  // AXI write channel
  // -------------------------------------------------------------------------------------------
  // AW and W are accepted together only; an outstanding response or a full FIFO holds ready low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= s_awvalid & s_wvalid & ~r_awready & ~r_bvalid & ~w_full;
      if (w_push) begin
        r_bvalid <= 1'b1;
      end else if (s_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  assign s_awready = r_awready;
  assign s_wready  = r_awready;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = 2'b00;

  // -------------------------------------------------------------------------------------------
  // AXI read channel
  // -------------------------------------------------------------------------------------------
  assign w_count8 = 8'(r_count);
  assign w_status = {16'h0000, w_count8, 5'b00000, w_busy, w_full, w_empty};

  always_comb begin
    w_rdata_next = 32'h0000_0000;
    if (s_araddr[3:2] == 2'b00) begin
      w_rdata_next = w_status;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_arvalid & ~r_arready & ~r_rvalid;
      if (r_arready & s_arvalid) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata_next;
      end else if (s_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = 2'b00;

  // -------------------------------------------------------------------------------------------
  // Serializer FSM
  // -------------------------------------------------------------------------------------------
  // r_txd is registered so the line changes one cycle after each state decision. r_shift is
  // shifted right by one per data bit; after eight bits the next byte already sits in [7:0],
  // which gives the per-byte ">> 8" advance without a separate shift in STOP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_baud     <= '0;
      r_txd      <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_txd <= 1'b1;
          if (!w_empty) begin
            r_shift    <= r_mem[r_rptr];
            r_byte_idx <= '0;
            r_baud     <= '0;
            r_txd      <= 1'b0;
            r_state    <= StStart;
          end
        end

        StStart: begin
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
            r_state   <= StData;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end

        StData: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[31:1]};
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= StStop;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end

        StStop: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_byte_idx == 2'd3) begin
              r_state <= StIdle;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_txd      <= 1'b0;
              r_state    <= StStart;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end

        default: begin
          r_state <= StIdle;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign txd = r_txd;

  // Address bits outside the decode, the write address and the strobes carry no meaning here.
  assign w_unused_ok = ^{s_awaddr, s_wstrb, s_araddr[12:4], s_araddr[1:0]};

endmodule

// File: tb/tb_uart_tx_axi_slave.sv
module tb_uart_tx_axi_slave;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CPB   = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [12:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = 4'hF;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [12:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic        txd;

  uart_tx_axi_slave #(
    .DEPTH      (DEPTH),
    .CLK_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_awaddr (s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_bresp  (s_bresp),
    .s_bvalid (s_bvalid),
    .s_bready (s_bready),
    .s_araddr (s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rvalid (s_rvalid),
    .s_rready (s_rready),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic        seen_wready;
  logic [7:0]  rx_q[$];
  int unsigned st_q[$];
  logic [7:0]  exp_q[$];
  int          mon_ferr = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a write at the current sample point; returns after the handshake edge.
  task automatic axi_write(input logic [31:0] d, input int budget, output bit ok);
    ok = 1'b0;
    s_wdata   = d;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (s_awready === 1'b1) begin
        ok = 1'b1;
        seen_wready = s_wready;
        break;
      end
    end
    if (ok) tick(1);
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  task automatic axi_read(input logic [12:0] a, input int hold, output logic [31:0] d,
                          output logic held);
    bit ok;
    ok = 1'b0;
    s_araddr  = a;
    s_arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (s_arready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) tick(1);
    s_arvalid = 1'b0;
    d = ok ? s_rdata : 'x;
    repeat (hold) tick(1);
    held = s_rvalid;
    s_rready = 1'b1;
    tick(1);
    s_rready = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int i;
    i = 0;
    while (rx_q.size() < n && i < budget) begin
      tick(1);
      i++;
    end
    check("rx_byte_count", rx_q.size(), n);
  endtask

  task automatic compare_rx(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
    end
  endtask

  // UART receiver: samples the middle of each bit once a start bit is seen.
  initial begin : uart_mon
    logic [7:0]  b;
    int unsigned st;
    forever begin
      @(posedge clk);
      #1;
      if (rstn === 1'b1 && txd === 1'b0) begin
        st = cyc;
        tick(2);
        if (txd !== 1'b0) mon_ferr++;
        for (int i = 0; i < 8; i++) begin
          tick(4);
          b[i] = txd;
        end
        tick(4);
        if (txd !== 1'b1) mon_ferr++;
        rx_q.push_back(b);
        st_q.push_back(st);
      end
    end
  end

  initial begin : stim
    logic [31:0] rd;
    logic        held;
    bit          ok;
    int unsigned e0;
    int          bad;
    logic [31:0] t2_words [6];
    logic [31:0] t5_words [4];
    t2_words = '{32'h11223344, 32'h55667788, 32'h99AABBCC,
                 32'hDDEEFF00, 32'h0F1E2D3C, 32'hA5C3965A};
    t5_words = '{32'hCAFEF00D, 32'h8BADF00D, 32'hDEADBEEF, 32'h0BADC0DE};

    // Reset values
    tick(3);
    check("rst_txd", {31'h0, txd}, 32'h1);
    check("rst_handshakes", {27'h0, s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 32'h0);
    check("rst_rdata", s_rdata, 32'h0);
    check("resp_okay", {28'h0, s_bresp, s_rresp}, 32'h0);
    rstn = 1'b1;
    tick(2);

    // Status reads while idle and empty
    axi_read(13'h000, 3, rd, held);
    check("status_idle", rd, 32'h0000_0001);
    check("rvalid_held", {31'h0, held}, 32'h1);
    check("rvalid_drop", {31'h0, s_rvalid}, 32'h0);
    axi_read(13'h008, 0, rd, held);
    check("addr8_zero", rd, 32'h0);
    axi_read(13'h004, 0, rd, held);
    check("addr4_zero", rd, 32'h0);

    // Single word "ABCD"
    rx_q.delete(); st_q.delete(); exp_q.delete();
    axi_write(32'h4443_4241, 10, ok);
    e0 = cyc + 1;
    check("w1_accept", {31'h0, ok}, 32'h1);
    check("w1_wready_pair", {31'h0, seen_wready}, 32'h1);
    check("w1_awready_pulse", {31'h0, s_awready}, 32'h0);
    check("w1_bvalid", {31'h0, s_bvalid}, 32'h1);
    tick(1);
    check("w1_bvalid_done", {31'h0, s_bvalid}, 32'h0);
    push_word(32'h4443_4241);
    wait_rx(4, 400);
    compare_rx("abcd");
    check("abcd_first_start", st_q[0], e0);
    check("abcd_span", st_q[3] - st_q[0], 32'd120);
    tick(5);
    axi_read(13'h000, 0, rd, held);
    check("status_after_word", rd, 32'h0000_0001);

    // Fill: one word in flight, four queued, sixth stalls until a pop
    rx_q.delete(); st_q.delete(); exp_q.delete();
    axi_write(t2_words[0], 10, ok);
    e0 = cyc + 1;
    check("fill_w0", {31'h0, ok}, 32'h1);
    for (int k = 1; k < 5; k++) begin
      axi_write(t2_words[k], 10, ok);
      check($sformatf("fill_w%0d", k), {31'h0, ok}, 32'h1);
    end
    axi_read(13'h000, 0, rd, held);
    check("status_full", rd, 32'h0000_0406);
    axi_write(t2_words[5], 8, ok);
    check("full_stall", {31'h0, ok}, 32'h0);
    axi_write(t2_words[5], 300, ok);
    check("after_pop_accept", {31'h0, ok}, 32'h1);
    check("after_pop_time", cyc, e0 + 163);
    axi_read(13'h000, 0, rd, held);
    check("status_refull", rd, 32'h0000_0406);
    for (int k = 0; k < 6; k++) push_word(t2_words[k]);
    wait_rx(24, 2000);
    compare_rx("fill");
    tick(5);

    // Response back-pressure, then a push coinciding with a pop at count 2
    rx_q.delete(); st_q.delete(); exp_q.delete();
    s_bready = 1'b0;
    axi_write(t5_words[0], 10, ok);
    e0 = cyc + 1;
    tick(3);
    check("bvalid_hold", {31'h0, s_bvalid}, 32'h1);
    axi_write(t5_words[1], 6, ok);
    check("bp_no_accept", {31'h0, ok}, 32'h0);
    check("bvalid_still", {31'h0, s_bvalid}, 32'h1);
    s_bready = 1'b1;
    tick(1);
    check("bvalid_consumed", {31'h0, s_bvalid}, 32'h0);
    axi_write(t5_words[1], 10, ok);
    axi_write(t5_words[2], 10, ok);
    axi_read(13'h000, 0, rd, held);
    check("status_cnt2", rd, 32'h0000_0204);
    while (cyc < e0 + 159) tick(1);
    axi_write(t5_words[3], 4, ok);
    check("coinc_accept", {31'h0, ok}, 32'h1);
    check("coinc_time", cyc, e0 + 161);
    axi_read(13'h000, 0, rd, held);
    check("status_coinc", rd, 32'h0000_0204);
    for (int k = 0; k < 4; k++) push_word(t5_words[k]);
    wait_rx(16, 1500);
    compare_rx("coinc");
    check("coinc_next_start", st_q[4], e0 + 161);
    check("frame_errors", mon_ferr, 32'h0);
    tick(5);

    // Reset in the middle of a data bit
    axi_write(32'h0000_0000, 10, ok);
    e0 = cyc + 1;
    axi_write(32'h1234_5678, 10, ok);
    while (cyc < e0 + 10) tick(1);
    check("pre_rst_txd", {31'h0, txd}, 32'h0);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_txd_async", {31'h0, txd}, 32'h1);
    check("rst_async_hs", {29'h0, s_awready, s_bvalid, s_rvalid}, 32'h0);
    #20;
    rstn = 1'b1;
    tick(1);
    axi_read(13'h000, 0, rd, held);
    check("status_post_rst", rd, 32'h0000_0001);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (txd !== 1'b1) bad++;
    end
    check("idle_post_rst", bad, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
